// File: rtl/operand_stream_bank.sv
// Multi-bank operand store: lane-strobed bus writes, host readback, and lockstep wrap-around streaming.
// Optional OPERAND_BANK_CLEAR_EN adds clear_i for a bulk storage wipe while idle.
module operand_stream_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int DEPTH      = 4,
  parameter int NUM_BANKS  = 2,
  localparam int LANES  = BUS_WIDTH / DATA_WIDTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
`ifdef OPERAND_BANK_CLEAR_EN
  input  logic                           clear_i,
`endif
  input  logic                           write_enable_i,
  input  logic [BSEL_W-1:0]              bank_sel_i,
  input  logic [ADDR_W-1:0]              address_i,
  input  logic [BUS_WIDTH-1:0]           data_i,
  input  logic [LANES-1:0]               strobe_i,
  input  logic                           rd_en_i,
  output logic [BUS_WIDTH-1:0]           rd_data_o,
  output logic                           rd_valid_o,
  input  logic                           start_i,
  input  logic [NUM_BANKS*ADDR_W-1:0]    start_addr_i,
  input  logic [ADDR_W:0]                len_i,
  output logic [NUM_BANKS*BUS_WIDTH-1:0] stream_data_o,
  output logic                           stream_valid_o,
  input  logic                           stream_ready_i,
  output logic                           stream_last_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [BUS_WIDTH-1:0] mem_q [NUM_BANKS][DEPTH];
  logic [ADDR_W-1:0]   ptr_q [NUM_BANKS];
  logic [ADDR_W:0]     len_q, cnt_q;
  logic                idle, bank_ok, wr_go, start_go, hs, clr_req, clr_go;

`ifdef OPERAND_BANK_CLEAR_EN
  assign clr_req = clear_i;
`else
  assign clr_req = 1'b0;
`endif

  assign idle     = (state_q == S_IDLE);
  assign bank_ok  = ({1'b0, bank_sel_i} < (BSEL_W+1)'(NUM_BANKS));
  assign wr_go    = idle && write_enable_i && bank_ok;
  assign clr_go   = idle && clr_req;
  assign start_go = idle && start_i;
  assign hs       = stream_valid_o && stream_ready_i;

  assign busy_o         = !idle;
  assign stream_valid_o = (state_q == S_STREAM);
  assign done_o         = (state_q == S_DONE);
  assign stream_last_o  = stream_valid_o && (cnt_q == (len_q - (ADDR_W+1)'(1)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = (len_i == '0) ? S_DONE : S_STREAM;
      S_STREAM: if (hs && stream_last_o) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Stream pointers advance together; DEPTH is a power of two so the add wraps by itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_BANKS; k++) ptr_q[k] <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else if (start_go) begin
      for (int k = 0; k < NUM_BANKS; k++) ptr_q[k] <= start_addr_i[k*ADDR_W +: ADDR_W];
      len_q <= len_i;
      cnt_q <= '0;
    end else if (hs) begin
      for (int k = 0; k < NUM_BANKS; k++) ptr_q[k] <= ptr_q[k] + ADDR_W'(1);
      cnt_q <= cnt_q + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                    err_o <= 1'b0;
    else if (start_go)                              err_o <= 1'b0;
    else if (!idle && (write_enable_i || clr_req))  err_o <= 1'b1;
  end

  // Clear wins over a same-cycle write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int d = 0; d < DEPTH; d++) mem_q[b][d] <= '0;
    end else if (clr_go) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int d = 0; d < DEPTH; d++) mem_q[b][d] <= '0;
    end else if (wr_go) begin
      for (int l = 0; l < LANES; l++)
        if (strobe_i[l])
          mem_q[bank_sel_i][address_i][l*DATA_WIDTH +: DATA_WIDTH] <= data_i[l*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= bank_ok ? mem_q[bank_sel_i][address_i] : '0;
    end
  end

  always_comb begin
    stream_data_o = '0;
    for (int k = 0; k < NUM_BANKS; k++)
      stream_data_o[k*BUS_WIDTH +: BUS_WIDTH] = mem_q[k][ptr_q[k]];
  end

endmodule

// File: tb/tb_operand_stream_bank.sv
// Randomised bench for operand_stream_bank against a row-array model of the banks.
module tb_operand_stream_bank;
  localparam int DW = 32, BW = 64, DEP = 4, NB = 2, AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          write_enable_i;
  logic [0:0]    bank_sel_i;
  logic [AW-1:0] address_i;
  logic [BW-1:0] data_i;
  logic [1:0]    strobe_i;
  logic          rd_en_i;
  logic [BW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          start_i;
  logic [NB*AW-1:0] start_addr_i;
  logic [AW:0]   len_i;
  logic [NB*BW-1:0] stream_data_o;
  logic          stream_valid_o, stream_ready_i, stream_last_o;
  logic          busy_o, done_o, err_o;
`ifdef OPERAND_BANK_CLEAR_EN
  logic          clear_i = 1'b0;
`endif

  logic [BW-1:0] model [NB][DEP];
  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  operand_stream_bank dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef OPERAND_BANK_CLEAR_EN
    .clear_i(clear_i),
`endif
    .write_enable_i(write_enable_i), .bank_sel_i(bank_sel_i), .address_i(address_i),
    .data_i(data_i), .strobe_i(strobe_i), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .start_i(start_i), .start_addr_i(start_addr_i), .len_i(len_i),
    .stream_data_o(stream_data_o), .stream_valid_o(stream_valid_o),
    .stream_ready_i(stream_ready_i), .stream_last_o(stream_last_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic model_write(input int b, input int a, input logic [BW-1:0] d, input logic [1:0] s);
    for (int l = 0; l < 2; l++)
      if (s[l]) model[b][a][l*DW +: DW] = d[l*DW +: DW];
  endtask

  task automatic do_write(input int b, input int a, input logic [BW-1:0] d, input logic [1:0] s);
    write_enable_i = 1'b1; bank_sel_i = b[0]; address_i = a[AW-1:0]; data_i = d; strobe_i = s;
    tick();
    write_enable_i = 1'b0;
    model_write(b, a, d, s);
  endtask

  task automatic host_read(input int b, input int a);
    rd_en_i = 1'b1; bank_sel_i = b[0]; address_i = a[AW-1:0];
    tick();
    rd_en_i = 1'b0;
    check_val("rd_valid", rd_valid_o, 1'b1);
    check_val("rd_data", rd_data_o, model[b][a]);
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0 repeating; 2: random ready
  task automatic run_stream(input int sa0, input int sa1, input int ln, input int mode, input bit do_wr);
    int beat, cyc, done_cyc, p, wb, wa;
    logic rdy;
    logic [BW-1:0] wd;
    start_i = 1'b1;
    start_addr_i = {sa1[AW-1:0], sa0[AW-1:0]};
    len_i = ln[AW:0];
    if (do_wr) begin
      wb = $urandom_range(0, NB-1); wa = $urandom_range(0, DEP-1); wd = {$urandom, $urandom};
      write_enable_i = 1'b1; bank_sel_i = wb[0]; address_i = wa[AW-1:0]; data_i = wd; strobe_i = 2'b11;
      model_write(wb, wa, wd, 2'b11);
    end
    tick();
    start_i = 1'b0; write_enable_i = 1'b0;
    cyc = 1; beat = 0; done_cyc = -1; p = 0;
    while (cyc < 60 && done_cyc < 0) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (p % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      p++;
      stream_ready_i = rdy;
      if (cyc == 1) check_val("err_cleared_by_start", err_o, 1'b0);
      if (done_o) begin
        check_val("done_no_valid", stream_valid_o, 1'b0);
        done_cyc = cyc;
      end
      if (stream_valid_o) begin
        check_val("beat_data", stream_data_o,
                  {model[1][(sa1 + beat) % DEP], model[0][(sa0 + beat) % DEP]});
        check_val("beat_last", stream_last_o, (beat == ln - 1));
        if (rdy) beat++;
      end
      tick();
      cyc++;
    end
    stream_ready_i = 1'b0;
    check_val("handshakes", beat, ln);
    check_val("done_seen", (done_cyc >= 0), 1'b1);
    if (mode == 0) check_val("done_cycle", done_cyc, ln + 1);
    check_val("busy_after_done", busy_o, 1'b0);
    check_val("done_one_cycle", done_o, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_ni = 1'b0; write_enable_i = 1'b0; bank_sel_i = '0; address_i = '0; data_i = '0;
    strobe_i = '0; rd_en_i = 1'b0; start_i = 1'b0; start_addr_i = '0; len_i = '0;
    stream_ready_i = 1'b0;
    for (int b = 0; b < NB; b++) for (int d = 0; d < DEP; d++) model[b][d] = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_rd_data", rd_data_o, '0);
    check_val("rst_rd_valid", rd_valid_o, 1'b0);
    check_val("rst_stream_data", stream_data_o, '0);
    check_val("rst_valid", stream_valid_o, 1'b0);
    check_val("rst_last", stream_last_o, 1'b0);
    check_val("rst_busy", busy_o, 1'b0);
    check_val("rst_done", done_o, 1'b0);
    check_val("rst_err", err_o, 1'b0);
    rst_ni = 1'b1;
    tick();

    host_read(1, 3);
    tick();
    check_val("rd_valid_pulse", rd_valid_o, 1'b0);

    do_write(0, 2, 64'h11112222_33334444, 2'b01);
    do_write(0, 2, 64'hAAAABBBB_CCCCDDDD, 2'b10);
    host_read(0, 2);
    check_val("strobe_merge", rd_data_o, 64'hAAAABBBB_33334444);
    tick();
    check_val("rd_data_hold", rd_data_o, 64'hAAAABBBB_33334444);

    for (int b = 0; b < NB; b++)
      for (int d = 0; d < DEP; d++)
        do_write(b, d, {$urandom, $urandom}, 2'($urandom_range(1, 3)));
    for (int b = 0; b < NB; b++)
      for (int d = 0; d < DEP; d++) host_read(b, d);

    // same-cycle write and read of one row returns the old contents
    write_enable_i = 1'b1; rd_en_i = 1'b1; bank_sel_i = 1'b1; address_i = 2'd1;
    data_i = {$urandom, $urandom}; strobe_i = 2'b11;
    tick();
    write_enable_i = 1'b0; rd_en_i = 1'b0;
    check_val("rd_old_data", rd_data_o, model[1][1]);
    model_write(1, 1, data_i, 2'b11);
    host_read(1, 1);

    run_stream(3, 1, 4, 0, 1'b0);
    run_stream(3, 1, 4, 1, 1'b0);
    check_val("err_after_toggle", err_o, 1'b0);

    // write while streaming is dropped and flagged
    stream_ready_i = 1'b0; start_i = 1'b1; start_addr_i = '0; len_i = 3'd2;
    tick();
    start_i = 1'b0;
    write_enable_i = 1'b1; bank_sel_i = 1'b0; address_i = 2'd1; data_i = {$urandom, $urandom}; strobe_i = 2'b11;
    tick();
    write_enable_i = 1'b0;
    check_val("err_set", err_o, 1'b1);
    check_val("busy_stream", busy_o, 1'b1);
    stream_ready_i = 1'b1;
    n = 0;
    while (busy_o && n < 20) begin tick(); n++; end
    stream_ready_i = 1'b0;
    check_val("busy_drop", busy_o, 1'b0);
    check_val("err_sticky", err_o, 1'b1);
    host_read(0, 1);
    run_stream(0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++)
      run_stream($urandom_range(0, DEP-1), $urandom_range(0, DEP-1), $urandom_range(0, DEP),
                 (i < 3) ? 0 : 2, 1'b1);

    // reset in the middle of a stream
    stream_ready_i = 1'b1; start_i = 1'b1; start_addr_i = 4'b0110; len_i = 3'd4;
    tick();
    start_i = 1'b0;
    check_val("mid_valid_b1", stream_valid_o, 1'b1);
    tick();
    rst_ni = 1'b0;
    #1;
    check_val("mid_rst_valid", stream_valid_o, 1'b0);
    check_val("mid_rst_busy", busy_o, 1'b0);
    check_val("mid_rst_done", done_o, 1'b0);
    stream_ready_i = 1'b0;
    for (int b = 0; b < NB; b++) for (int d = 0; d < DEP; d++) model[b][d] = '0;
    repeat (2) begin tick(); check_val("rst_no_done", done_o, 1'b0); end
    rst_ni = 1'b1;
    tick();
    check_val("post_rst_done", done_o, 1'b0);
    for (int b = 0; b < NB; b++)
      for (int d = 0; d < DEP; d++) host_read(b, d);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
